// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, block type and padding rule for the padder and compression stages.
package sha256_pkg;

  localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

  // Element 0 occupies the most significant 32 bits of the block.
  typedef logic [0:15][31:0] sha256_block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_FIN
  } pad_state_t;

  localparam logic [31:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] SHA256_IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Padded word g of an L-word message spanning nblk blocks; message words (g<L) return 0
  // because the caller substitutes memory data for them.
  function automatic logic [31:0] sha256_pad_word(input logic [31:0] g,
                                                  input logic [31:0] len,
                                                  input logic [31:0] nblk);
    logic [31:0] last_g;
    last_g = (nblk << 4) - 32'd1;
    if (g < len)                return 32'h0;
    else if (g == len)          return SHA256_PAD_WORD;
    else if (g == last_g - 1)   return 32'h0;
    else if (g == last_g)       return len << 5;
    else                        return 32'h0;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Streams a memory-resident message as SHA-256 padded 512-bit blocks; first block 17 cycles after start,
// each further block 17 cycles after the previous handshake; a stalled block holds stable until blk_ready.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [LEN_W-1:0]  num_words,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [511:0]      blk_data,
  output logic [7:0]        blk_index,
  output logic              blk_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = LEN_W + 1;
  localparam int G_W   = CNT_W + 4;

  pad_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  nblk_q;
  logic [CNT_W-1:0]  blk_cnt;
  logic [4:0]        slot_cnt;
  logic              pipe_vld;
  logic              pipe_mem;
  logic [3:0]        pipe_slot;
  logic [31:0]       pipe_word;
  sha256_block_t     blk_buf;

  logic              issue;
  logic [G_W-1:0]    g_issue;
  logic              g_is_msg;
  logic              last_blk;

  assign g_issue  = {blk_cnt, slot_cnt[3:0]};
  assign issue    = (state_q == ST_LOAD) && !slot_cnt[4];
  assign g_is_msg = g_issue < G_W'(len_q);
  assign last_blk = blk_cnt == (nblk_q - CNT_W'(1));

  assign blk_data  = blk_buf;
  assign blk_index = blk_cnt[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (pipe_vld && pipe_slot == 4'd15) state_d = ST_EMIT;
      ST_EMIT: if (blk_ready) state_d = last_blk ? ST_FIN : ST_LOAD;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_LOAD) || (state_q == ST_EMIT);
    done      = (state_q == ST_FIN);
    blk_valid = (state_q == ST_EMIT);
    blk_last  = (state_q == ST_EMIT) && last_blk;
    mem_re    = issue && g_is_msg;
    mem_addr  = mem_re ? base_q + ADDR_W'(g_issue) : '0;
  end

  // Issue stage tags each slot; the write stage lands it in the buffer one cycle later,
  // when a memory read issued alongside it has returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      len_q     <= '0;
      nblk_q    <= '0;
      blk_cnt   <= '0;
      slot_cnt  <= '0;
      pipe_vld  <= 1'b0;
      pipe_mem  <= 1'b0;
      pipe_slot <= '0;
      pipe_word <= '0;
      blk_buf   <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        base_q   <= message_addr;
        len_q    <= num_words;
        nblk_q   <= (CNT_W'(num_words) + CNT_W'(18)) >> 4;
        blk_cnt  <= '0;
        slot_cnt <= '0;
      end else if (state_q == ST_EMIT && blk_ready && !last_blk) begin
        blk_cnt  <= blk_cnt + CNT_W'(1);
        slot_cnt <= '0;
      end else if (issue) begin
        slot_cnt <= slot_cnt + 5'd1;
      end

      pipe_vld  <= issue;
      pipe_slot <= slot_cnt[3:0];
      pipe_mem  <= g_is_msg;
      pipe_word <= sha256_pad_word(32'(g_issue), 32'(len_q), 32'(nblk_q));

      if (pipe_vld) blk_buf[pipe_slot] <= pipe_mem ? mem_read_data : pipe_word;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: fixed message lengths, backpressure and mid-run reset.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  message_addr = '0;
  logic [15:0]  num_words = '0;
  logic         mem_re;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_read_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic [7:0]   blk_index;
  logic         blk_last;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int re_total = 0;
  int done_total = 0;
  int bad_re = 0;

  logic [31:0] mem [0:255];

  sha256_msg_padder #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .message_addr(message_addr),
    .num_words(num_words), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_read_data(mem_read_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_index(blk_index), .blk_last(blk_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr[7:0]];
    if (mem_re) re_total <= re_total + 1;
    if (done) done_total <= done_total + 1;
    if (mem_re && (blk_valid || !busy)) bad_re <= bad_re + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic do_start(input logic [15:0] addr, input logic [15:0] len);
    message_addr = addr;
    num_words = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_blk(output int cyc);
    cyc = 0;
    while (!blk_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept();
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_re, blk_valid, blk_last, busy, done} !== 5'b0 || blk_index !== 8'h0 ||
        mem_addr !== 16'h0 || blk_data !== 512'h0) begin
      errors++;
      $display("FAIL reset_state got re=%b v=%b last=%b busy=%b done=%b idx=%h addr=%h want all zero",
               mem_re, blk_valid, blk_last, busy, done, blk_index, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_l20();
    int cyc, re0, d0;
    logic [31:0] wd, exp;
    re0 = re_total;
    d0 = done_total;
    do_start(16'h0010, 16'd20);
    for (int b = 0; b < 2; b++) begin
      wait_blk(cyc);
      checks++;
      if (cyc !== 17) begin errors++; $display("FAIL l20_latency b%0d got %0d want 17", b, cyc); end
      checks++;
      if (blk_index !== 8'(b) || blk_last !== (b == 1)) begin
        errors++;
        $display("FAIL l20_index b%0d got idx=%0d last=%b want idx=%0d last=%b", b, blk_index, blk_last, b, b == 1);
      end
      for (int w = 0; w < 16; w++) begin
        wd = blk_data[511-32*w -: 32];
        if (b == 0)      exp = 32'(w + 1);
        else if (w < 4)  exp = 32'(w + 17);
        else if (w == 4) exp = 32'h8000_0000;
        else if (w == 15) exp = 32'h0000_0280;
        else             exp = 32'h0;
        checks++;
        if (wd !== exp) begin errors++; $display("FAIL l20_b%0d_w%0d got %h want %h", b, w, wd, exp); end
      end
      accept();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL l20_done_pulse got done=%b busy=%b v=%b want 1 0 0", done, busy, blk_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL l20_done_width got %b want 0", done); end
    checks++;
    if (re_total - re0 !== 20) begin errors++; $display("FAIL l20_mem_re_count got %0d want 20", re_total - re0); end
    checks++;
    if (done_total - d0 !== 1) begin errors++; $display("FAIL l20_done_count got %0d want 1", done_total - d0); end
  endtask

  task automatic test_l13(input string tag);
    int cyc;
    logic [31:0] wd, exp;
    do_start(16'h0010, 16'd13);
    wait_blk(cyc);
    checks++;
    if (cyc !== 17) begin errors++; $display("FAIL %s_latency got %0d want 17", tag, cyc); end
    checks++;
    if (blk_index !== 8'd0 || blk_last !== 1'b1) begin
      errors++;
      $display("FAIL %s_index got idx=%0d last=%b want 0 1", tag, blk_index, blk_last);
    end
    for (int w = 0; w < 16; w++) begin
      wd = blk_data[511-32*w -: 32];
      if (w < 13)       exp = 32'(w + 1);
      else if (w == 13) exp = 32'h8000_0000;
      else if (w == 15) exp = 32'h0000_01A0;
      else              exp = 32'h0;
      checks++;
      if (wd !== exp) begin errors++; $display("FAIL %s_w%0d got %h want %h", tag, w, wd, exp); end
    end
    accept();
    @(negedge clk);
  endtask

  task automatic test_l14();
    int cyc;
    logic [31:0] wd, exp;
    do_start(16'h0010, 16'd14);
    for (int b = 0; b < 2; b++) begin
      wait_blk(cyc);
      checks++;
      if (blk_index !== 8'(b) || blk_last !== (b == 1)) begin
        errors++;
        $display("FAIL l14_index b%0d got idx=%0d last=%b", b, blk_index, blk_last);
      end
      for (int w = 0; w < 16; w++) begin
        wd = blk_data[511-32*w -: 32];
        if (b == 0 && w < 14)       exp = 32'(w + 1);
        else if (b == 0 && w == 14) exp = 32'h8000_0000;
        else if (b == 1 && w == 15) exp = 32'h0000_01C0;
        else                        exp = 32'h0;
        checks++;
        if (wd !== exp) begin errors++; $display("FAIL l14_b%0d_w%0d got %h want %h", b, w, wd, exp); end
      end
      accept();
    end
    @(negedge clk);
  endtask

  task automatic test_l0();
    int cyc, re0;
    logic [31:0] wd, exp;
    re0 = re_total;
    do_start(16'h0010, 16'd0);
    wait_blk(cyc);
    checks++;
    if (blk_last !== 1'b1 || blk_index !== 8'd0) begin
      errors++;
      $display("FAIL l0_index got idx=%0d last=%b want 0 1", blk_index, blk_last);
    end
    for (int w = 0; w < 16; w++) begin
      wd = blk_data[511-32*w -: 32];
      exp = (w == 0) ? 32'h8000_0000 : 32'h0;
      checks++;
      if (wd !== exp) begin errors++; $display("FAIL l0_w%0d got %h want %h", w, wd, exp); end
    end
    accept();
    @(negedge clk);
    checks++;
    if (re_total - re0 !== 0) begin errors++; $display("FAIL l0_mem_re got %0d want 0", re_total - re0); end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [511:0] snap;
    do_start(16'h0010, 16'd20);
    for (int b = 0; b < 2; b++) begin
      wait_blk(cyc);
      snap = blk_data;
      for (int k = 0; k < 10; k++) begin
        if (k == 3) begin
          num_words = 16'd13;
          start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (blk_valid !== 1'b1 || blk_data !== snap || blk_index !== 8'(b) ||
            blk_last !== (b == 1) || busy !== 1'b1) begin
          errors++;
          $display("FAIL bp_stable b%0d k%0d got v=%b idx=%0d last=%b busy=%b data_same=%b",
                   b, k, blk_valid, blk_index, blk_last, busy, blk_data === snap);
        end
      end
      if (b == 1) begin
        checks++;
        if (blk_data[31:0] !== 32'h0000_0280 || blk_data[415:384] !== 32'd20) begin
          errors++;
          $display("FAIL bp_content got w15=%h w3=%h want 00000280 00000014", blk_data[31:0], blk_data[415:384]);
        end
      end
      accept();
    end
    repeat (25) @(negedge clk);
    checks++;
    if (blk_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_start_ignored got v=%b busy=%b want 0 0", blk_valid, busy);
    end
    checks++;
    if (bad_re !== 0) begin errors++; $display("FAIL mem_re_outside_load got %0d want 0", bad_re); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_start(16'h0010, 16'd20);
    wait_blk(cyc);
    accept();
    repeat (2) @(negedge clk);
    checks++;
    if (mem_re !== 1'b1 || blk_index !== 8'd1) begin
      errors++;
      $display("FAIL rst_mid_pre got re=%b idx=%0d want 1 1", mem_re, blk_index);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_re, blk_valid, blk_last, busy, done} !== 5'b0 || blk_index !== 8'h0 ||
        mem_addr !== 16'h0 || blk_data !== 512'h0) begin
      errors++;
      $display("FAIL rst_mid got re=%b v=%b last=%b busy=%b done=%b idx=%h addr=%h want all zero",
               mem_re, blk_valid, blk_last, busy, done, blk_index, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_l13("rst_l13");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i - 15);
    test_reset();
    test_l20();
    test_l13("l13");
    test_l14();
    test_l0();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Upstream feeder for the SHA-256 compression stage. Reads a raw message of run-time length (in 32-bit words) from the shared word-addressed memory, applies standard SHA-256 padding, and emits successive 512-bit blocks over a valid/ready handshake. Replaces hard-coded block assembly for a fixed 20-word message with a general padder.

Parameters:
ADDR_W, 16, memory word-address width
LEN_W, 16, width of num_words; message length L is 0 to 2^LEN_W-1 words

Ports:
clk  in  1  sole clock; rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
message_addr  in  ADDR_W  word address of message word 0; latched on start
num_words  in  LEN_W  message length L in words; latched on start
mem_re  out  1  read strobe to memory
mem_addr  out  ADDR_W  read address = message_addr + g
mem_read_data  in  32  read data, valid exactly 1 cycle after mem_re
blk_valid  out  1  blk_data holds a complete padded block
blk_ready  in  1  consumer accepts the block when blk_valid and blk_ready are both high
blk_data  out  512  word 0 in [511:480], word 15 in [31:0]
blk_index  out  8  index of current block, from 0
blk_last  out  1  current block is final; qualified by blk_valid
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the final block handshake

Behaviour:
- Reset, asynchronous: state=IDLE; mem_re, blk_valid, blk_last, busy, done = 0; blk_index, mem_addr, blk_data = 0. Reset mid-operation aborts the operation, emits no partial block, and takes effect immediately.
- Block count N = (L+18)/16, integer division: L+1 pad word+2 length words rounded up to whole blocks. Internal counters are LEN_W+1 bits wide, with no overflow at maximum L.
- Global padded word g = 16*blk_index + slot, slot 0..15:
  - g<L: mem_read_data
  - g==L: 32'h80000000
  - g==16N-2: 32'h0 (upper length word)
  - g==16N-1: L<<5, zero-extended to 32 bits
  - otherwise: 0
  - L==0 gives word0=0x80000000 and word15=0.
- FSM states: IDLE, LOAD, EMIT, FIN.
- IDLE: busy=0. start=1 latches message_addr and num_words, sets blk_index=0, and moves to LOAD. start is ignored in every other state.
- LOAD: advances one slot per cycle, slots 0..15 in order.
  - mem_re=1 only when g<L, with mem_addr=message_addr+g.
  - Every slot passes through a 1-stage pipeline (valid + slot tag + memory/pad select), so slot s is written at the edge following its issue.
  - After slot 15 is written, blk_valid=1 and the FSM moves to EMIT.
  - Latency: blk_valid rises exactly 17 cycles after the start-accept edge, and 17 cycles after each non-final handshake.
- EMIT: blk_data, blk_index and blk_last are stable while blk_valid && !blk_ready; mem_re=0.
  - On handshake, blk_valid drops next cycle.
  - If blk_last=0: blk_index increments and the FSM returns to LOAD.
  - If blk_last=1: the FSM goes to FIN.
- blk_last = (blk_index == N-1).
- FIN: done=1 for one cycle, busy=0, then IDLE. The start acceptance edge and the done pulse never coincide.
- Memory: read only; mem_re never asserts outside LOAD. Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared package sha256_pkg holds:
  - SHA256_PAD_WORD=32'h80000000
  - the block typedef (16 x 32-bit packed array)
  - the 64-entry K table and the 8 IV constants, shared with the compression stage
  - a pure function computing the padded word from (g, L, N)
- No sub-module: a single module with a small FSM plus a 16-word buffer.

Test Plan:
- L=20, message_addr=0x0010, mem[0x10+i]=i+1 -> 2 blocks.
  - Block 0: words 1..16.
  - Block 1: words 17..20, then 0x80000000, zeros, word15=0x00000280, blk_last=1.
  - Exactly 20 mem_re cycles; done pulses once.
- L=13 -> 1 block: word13=0x80000000, word14=0, word15=0x000001A0; blk_valid at start-edge+17.
- L=14 -> 2 blocks.
  - Block 0: word14=0x80000000, word15=0.
  - Block 1: all zero except word15=0x000001C0.
- L=0 -> 1 block: word0=0x80000000, all else 0, mem_re never asserted.
- L=20 with blk_ready held low for 10 cycles on each block -> blk_data, blk_index and blk_last stable, no mem_re during EMIT; start pulses during busy are ignored.
- Reset asserted mid-LOAD of block 1 -> all outputs 0 immediately. A new start with L=13 after release produces a correct single block with blk_index=0.
